// File: rtl/pipe_stage.sv
// Elastic register pipeline of DEPTH stages with per-stage flush,
// registered occupancy and a saturating count of flushed beats.
module pipe_stage #(
    parameter int DW    = 32,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                drop_cnt
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q   [DEPTH];
    logic [DW-1:0]    data_src [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH:0]   live_ext;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] valid_d;
    logic [OW-1:0]    occ_d;
    logic [3:0]       drops;
    logic [16:0]      drop_sum;
    logic             rdy_chain;

    // Handshake: a beat moves across a boundary on an edge where the sender is
    // live (valid and not flushed) and the receiver is ready; ready ripples
    // backwards from out_ready through every empty, flushed or draining stage.
    always_comb begin
        live      = valid_q & ~flush;
        live_ext  = {live, in_valid};
        rdy       = '0;
        rdy_chain = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_chain = !valid_q[i] || flush[i] || rdy_chain;
            rdy[i]    = rdy_chain;
        end
        data_src[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_src[i] = data_q[i-1];
        end
        load    = '0;
        valid_d = '0;
        occ_d   = '0;
        drops   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load[i]    = rdy[i] && live_ext[i];
            valid_d[i] = rdy[i] ? live_ext[i] : valid_q[i];
            occ_d      = occ_d + OW'(valid_d[i]);
            drops      = drops + 4'(valid_q[i] && flush[i]);
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drops);
    end

    // An empty pipeline always accepts, including while reset is held.
    assign in_ready  = rdy[0] || !rst;
    assign out_valid = live[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= '0;
            occupancy <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    data_q[i] <= data_src[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage (DW=8, DEPTH=3): directed scenarios with literal
// expectations plus randomized traffic against a beat-list model.
module tb_pipe_stage;
    localparam int DW    = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic [DEPTH-1:0] flush = '0;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready = 1'b0;
    logic [1:0]       occupancy;
    logic [15:0]      drop_cnt;

    pipe_stage #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            pos;
    } beat_t;

    int            n_checks = 0;
    int            n_pass   = 0;
    beat_t         mq[$];
    int            m_drop  = 0;
    bit            m_known = 1'b0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; flush = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    // Model: ordered list of live beats (oldest first) tagged with stage position.
    always @(negedge clk) begin : model_proc
        beat_t surv[$];
        beat_t nxt[$];
        int    bound, ndrop, p;
        bit    exp_ov;
        surv.delete();
        nxt.delete();
        ndrop = 0;
        foreach (mq[j]) begin
            if (flush[mq[j].pos]) ndrop++;
            else surv.push_back(mq[j]);
        end
        exp_ov = (surv.size() > 0) && (surv[0].pos == DEPTH - 1);
        bound  = DEPTH;
        foreach (surv[j]) begin
            p = surv[j].pos;
            if (p == DEPTH - 1 && out_ready) continue;
            if (p + 1 < bound) p = p + 1;
            nxt.push_back('{d: surv[j].d, pos: p});
            bound = p;
        end
        if (m_known) begin
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) check("out_data", 32'(out_data), 32'(surv[0].d));
            check("in_ready", 32'(in_ready), 32'(!rst || bound > 0));
        end else if (!rst) begin
            check("in_ready_in_reset", 32'(in_ready), 32'd1);
        end
        if (rst && out_valid && out_ready) got_q.push_back(out_data);
        if (!rst) begin
            mq.delete();
            m_drop  = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
            mq = nxt;
            if (in_valid && bound > 0) mq.push_back('{d: in_data, pos: 0});
        end
    end

    initial begin
        // Reset held two cycles with traffic on the inputs and out_ready low.
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        do_reset();

        // Streaming with no backpressure.
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 3);
            if (k < 3) in_data = vals[k];
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'(k >= 3 && k <= 5));
            if (k >= 3 && k <= 5) check("stream_out_data", 32'(out_data), 32'(vals[k-3]));
            next_cycle();
        end

        // Backpressure: fill, stall the fourth, then release.
        do_reset();
        begin
            int idx;
            idx = 0;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = vals[idx];
                @(negedge clk);
                check("bp_in_ready", 32'(in_ready), 32'(k < 3));
                if (k == 3) begin
                    check("bp_occupancy", 32'(occupancy), 32'd3);
                    check("bp_head", 32'(out_data), 32'h11);
                end
                next_cycle();
                if (k < 3) idx++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd1);
        check("bp_release_out_data", 32'(out_data), 32'h11);
        next_cycle();
        in_valid = 1'b0;
        repeat (5) next_cycle();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_seq("bp_seq");

        // Flush of the middle stage while stalled.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = vals[k];
            next_cycle();
        end
        in_valid = 1'b0; flush = 3'b010;
        next_cycle();
        flush = '0;
        @(negedge clk);
        check("mid_occupancy", 32'(occupancy), 32'd2);
        check("mid_drop_cnt", 32'(drop_cnt), 32'd1);
        check("mid_model_size", 32'(mq.size()), 32'd2);
        check("mid_model_drop", 32'(m_drop), 32'd1);
        next_cycle();
        out_ready = 1'b1;
        repeat (4) next_cycle();
        exp_q = '{8'h11, 8'h33};
        check_seq("mid_seq");

        // Flush of the output stage while downstream is ready.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 0); in_data = 8'h11;
            flush = (k == 3) ? 3'b100 : 3'b000;
            @(negedge clk);
            if (k == 3) check("oflush_out_valid", 32'(out_valid), 32'd0);
            if (k == 4) begin
                check("oflush_drop_cnt", 32'(drop_cnt), 32'd1);
                check("oflush_occupancy", 32'(occupancy), 32'd0);
            end
            next_cycle();
        end
        repeat (2) next_cycle();
        check("oflush_delivered", 32'(got_q.size()), 32'd0);

        // Drop counter saturation: one flushed beat per cycle.
        do_reset();
        in_valid = 1'b1; in_data = 8'h5A; flush = 3'b111;
        repeat (65540) next_cycle();
        @(negedge clk);
        check("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
        next_cycle();
        @(negedge clk);
        check("sat_hold", 32'(drop_cnt), 32'hFFFF);
        check("sat_model", 32'(m_drop), 32'd65535);
        next_cycle();
        in_valid = 1'b0; flush = '0;

        // Reset while the pipeline is full, then resume.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = vals[k];
            next_cycle();
        end
        rst = 1'b0; in_data = 8'h44; flush = 3'b010;
        next_cycle();
        rst = 1'b1; in_valid = 1'b0; flush = '0;
        @(negedge clk);
        check("mrst_occupancy", 32'(occupancy), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
        next_cycle();
        got_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 2);
            in_data  = (k == 0) ? 8'h55 : 8'h66;
            next_cycle();
        end
        exp_q = '{8'h55, 8'h66};
        check_seq("mrst_seq");

        // Randomized traffic, flushes and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            next_cycle();
        end
        rst = 1'b1; in_valid = 1'b0; flush = '0; out_ready = 1'b1;
        repeat (4) next_cycle();
        @(negedge clk);
        check("final_empty", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
